// File: rtl/cruise_controller_pkg.sv
// Shared encodings for the cruise-control sequencer: FSM states, compare
// results and the default speed width.
package cruise_pkg;

    localparam int SPEED_W = 8;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SNAP   = 2'd1,
        CMP    = 2'd2,
        UPDATE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        ACCEL = 2'd1,
        DECEL = 2'd2
    } result_t;

endpackage

// File: rtl/cruise_controller_comparator.sv
// Existing 1-bit magnitude comparator (greater / equal / less), reused as the
// bit-serial compare datapath of cruise_controller.
module comparator (
    input  logic a,
    input  logic b,
    input  logic enable,
    output logic g,
    output logic eq,
    output logic l
);

    assign g  = enable & a & ~b;
    assign l  = enable & ~a & b;
    assign eq = enable & ~(a ^ b);

endmodule

// File: rtl/cruise_controller.sv
// Cruise-control sequencer: latches a set speed and repeatedly compares a
// snapshot of the live speed against it MSB-first, one bit per cycle.
// Optional feature: define CRUISE_RESUME_EN to keep the set speed across a
// disengage and allow re-engaging with resume.
module cruise_controller
    import cruise_pkg::*;
#(
    parameter int W = SPEED_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cruise_on,
    input  logic         set,
    input  logic         resume,
    input  logic         brake,
    input  logic [W-1:0] speed,
    output logic         accel,
    output logic         decel,
    output logic         active,
    output logic [W-1:0] set_speed,
    output logic         cmp_done
);

    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

    state_t           state_r,     state_next_s;
    result_t          pending_r,   pending_next_s;
    logic [IDX_W-1:0] bit_idx_r,   bit_idx_next_s;
    logic [W-1:0]     speed_q_r,   speed_q_next_s;
    logic [W-1:0]     set_speed_r, set_speed_next_s;
    logic             set_valid_r, set_valid_next_s;
    logic             accel_r,     accel_next_s;
    logic             decel_r,     decel_next_s;
    logic             cmp_done_r,  cmp_done_next_s;
    logic             active_r,    active_next_s;
    logic             disengage_s;
    logic             cmp_g_s, cmp_eq_s, cmp_l_s;

    comparator u_comparator (
        .a      (speed_q_r[bit_idx_r]),
        .b      (set_speed_r[bit_idx_r]),
        .enable (1'b1),
        .g      (cmp_g_s),
        .eq     (cmp_eq_s),
        .l      (cmp_l_s)
    );

    assign disengage_s = brake | ~cruise_on;

`ifndef CRUISE_RESUME_EN
    logic unused_resume_s;
    assign unused_resume_s = resume;
`endif

    // Next-state and next-output logic, priority: disengage > set > resume > FSM.
    always_comb begin
        state_next_s     = state_r;
        pending_next_s   = pending_r;
        bit_idx_next_s   = bit_idx_r;
        speed_q_next_s   = speed_q_r;
        set_speed_next_s = set_speed_r;
        set_valid_next_s = set_valid_r;
        accel_next_s     = accel_r;
        decel_next_s     = decel_r;
        cmp_done_next_s  = 1'b0;

        if (disengage_s) begin
            state_next_s = OFF;
            accel_next_s = 1'b0;
            decel_next_s = 1'b0;
`ifdef CRUISE_RESUME_EN
            set_valid_next_s = set_valid_r;
`else
            set_valid_next_s = 1'b0;
`endif
        end else if (set) begin
            // Abandon any compare in progress; accel/decel hold until the next UPDATE.
            set_speed_next_s = speed;
            set_valid_next_s = 1'b1;
            state_next_s     = SNAP;
`ifdef CRUISE_RESUME_EN
        end else if (resume && set_valid_r && (state_r == OFF)) begin
            state_next_s = SNAP;
`endif
        end else begin
            case (state_r)
                OFF: begin
                    accel_next_s = 1'b0;
                    decel_next_s = 1'b0;
                end
                SNAP: begin
                    speed_q_next_s = speed;
                    bit_idx_next_s = IDX_MAX;
                    state_next_s   = CMP;
                end
                CMP: begin
                    if (cmp_g_s) begin
                        pending_next_s = DECEL;
                        state_next_s   = UPDATE;
                    end else if (cmp_l_s) begin
                        pending_next_s = ACCEL;
                        state_next_s   = UPDATE;
                    end else if (cmp_eq_s && (bit_idx_r == IDX_ZERO)) begin
                        pending_next_s = HOLD;
                        state_next_s   = UPDATE;
                    end else begin
                        bit_idx_next_s = bit_idx_r - IDX_ONE;
                    end
                end
                UPDATE: begin
                    accel_next_s    = (pending_r == ACCEL);
                    decel_next_s    = (pending_r == DECEL);
                    cmp_done_next_s = 1'b1;
                    state_next_s    = SNAP;
                end
                default: begin
                    state_next_s = OFF;
                    accel_next_s = 1'b0;
                    decel_next_s = 1'b0;
                end
            endcase
        end

        active_next_s = (state_next_s != OFF);
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= OFF;
            pending_r   <= HOLD;
            bit_idx_r   <= IDX_MAX;
            speed_q_r   <= {W{1'b0}};
            set_speed_r <= {W{1'b0}};
            set_valid_r <= 1'b0;
            accel_r     <= 1'b0;
            decel_r     <= 1'b0;
            cmp_done_r  <= 1'b0;
            active_r    <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            pending_r   <= pending_next_s;
            bit_idx_r   <= bit_idx_next_s;
            speed_q_r   <= speed_q_next_s;
            set_speed_r <= set_speed_next_s;
            set_valid_r <= set_valid_next_s;
            accel_r     <= accel_next_s;
            decel_r     <= decel_next_s;
            cmp_done_r  <= cmp_done_next_s;
            active_r    <= active_next_s;
        end
    end

    assign accel     = accel_r;
    assign decel     = decel_r;
    assign active    = active_r;
    assign set_speed = set_speed_r;
    assign cmp_done  = cmp_done_r;

endmodule

// File: tb/tb_cruise_controller.sv
// Self-checking bench for cruise_controller: directed scenarios plus a
// randomized run, all checked against a cycle-accurate behavioural model.
module tb_cruise_controller;

    localparam int W = 8;
`ifdef CRUISE_RESUME_EN
    localparam logic RES_EN = 1'b1;
`else
    localparam logic RES_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, cruise_on, set, resume, brake;
    logic [W-1:0] speed;
    logic         accel, decel, active, cmp_done;
    logic [W-1:0] set_speed;

    int checks = 0;
    int errors = 0;

    // Behavioural model: engaged flag, pending snapshot, cycles to next result.
    logic         m_eng, m_snap, m_set_valid, m_accel, m_decel, m_done;
    logic [W-1:0] m_set_speed, m_snapq;
    int           m_cnt;

    cruise_controller #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cruise_on (cruise_on),
        .set       (set),
        .resume    (resume),
        .brake     (brake),
        .speed     (speed),
        .accel     (accel),
        .decel     (decel),
        .active    (active),
        .set_speed (set_speed),
        .cmp_done  (cmp_done)
    );

    always #5 clk = ~clk;

    // Number of compare cycles: one per bit down to the first difference.
    function automatic int cmp_cycles(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        x = a ^ b;
        for (int i = W - 1; i >= 0; i--) begin
            if (x[i]) return W - i;
        end
        return W;
    endfunction

    function automatic logic [W+3:0] exp_vec();
        return {m_accel, m_decel, m_eng, m_done, m_set_speed};
    endfunction

    task automatic model_reset();
        m_eng = 1'b0; m_snap = 1'b0; m_set_valid = 1'b0;
        m_accel = 1'b0; m_decel = 1'b0; m_done = 1'b0;
        m_set_speed = '0; m_snapq = '0; m_cnt = 0;
    endtask

    task automatic model_step();
        m_done = 1'b0;
        if (brake || !cruise_on) begin
            m_eng = 1'b0; m_accel = 1'b0; m_decel = 1'b0;
            if (!RES_EN) m_set_valid = 1'b0;
        end else if (set) begin
            m_set_speed = speed; m_set_valid = 1'b1; m_eng = 1'b1; m_snap = 1'b1;
        end else if (RES_EN && resume && m_set_valid && !m_eng) begin
            m_eng = 1'b1; m_snap = 1'b1;
        end else if (m_eng) begin
            if (m_snap) begin
                m_snapq = speed; m_snap = 1'b0;
                m_cnt = cmp_cycles(speed, m_set_speed) + 1;
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_accel = (m_snapq < m_set_speed);
                    m_decel = (m_snapq > m_set_speed);
                    m_done  = 1'b1;
                    m_snap  = 1'b1;
                end
            end
        end
    endtask

    // Drive inputs (at negedge), advance model and DUT by one edge, return at negedge.
    task automatic tick(input logic c, input logic s, input logic r, input logic b,
                        input logic [W-1:0] sp);
        cruise_on = c; set = s; resume = r; brake = b; speed = sp;
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({accel, decel, active, cmp_done, set_speed} !== '0) begin
            errors++;
            $display("FAIL reset_values: got %b expected all zero", {accel, decel, active, cmp_done, set_speed});
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd55);
        checks++;
        if ({accel, decel, active, cmp_done, set_speed} !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle: got %b expected %b", {accel, decel, active, cmp_done, set_speed}, exp_vec());
        end
    endtask

    // Engage at set_sp, present run_sp from the snapshot on, check loop period and result.
    task automatic test_periodic(input string name, input logic [W-1:0] set_sp,
                                 input logic [W-1:0] run_sp, input int period,
                                 input logic exp_acc, input logic exp_dec);
        int prev;
        int pulses;
        prev = -1;
        pulses = 0;
        tick(1'b1, 1'b1, 1'b0, 1'b0, set_sp);
        tick(1'b1, 1'b0, 1'b0, 1'b0, run_sp);
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, run_sp);
            checks++;
            if ({accel, decel, active, cmp_done, set_speed} !== exp_vec()) begin
                errors++;
                $display("FAIL %s_cycle%0d: got %b expected %b", name, i, {accel, decel, active, cmp_done, set_speed}, exp_vec());
            end
            if (cmp_done === 1'b1) begin
                pulses++;
                if (prev >= 0) begin
                    checks++;
                    if (i - prev != period) begin
                        errors++;
                        $display("FAIL %s_period: got %0d expected %0d", name, i - prev, period);
                    end
                end
                prev = i;
            end
        end
        checks++;
        if (accel !== exp_acc || decel !== exp_dec || pulses < 3) begin
            errors++;
            $display("FAIL %s_result: got accel=%b decel=%b pulses=%0d expected accel=%b decel=%b pulses>=3",
                     name, accel, decel, pulses, exp_acc, exp_dec);
        end
    endtask

    task automatic test_reset_mid_compare();
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'd60);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd50);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'd50);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd50);
        checks++;
        if (active !== 1'b1 || accel !== 1'b1) begin
            errors++;
            $display("FAIL midcmp_pre: got active=%b accel=%b expected 1 1", active, accel);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({accel, decel, active, cmp_done, set_speed} !== '0) begin
            errors++;
            $display("FAIL midcmp_async: got %b expected all zero", {accel, decel, active, cmp_done, set_speed});
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 8'(i * 7));
            checks++;
            if ({accel, decel, active, cmp_done, set_speed} !== exp_vec() || active !== 1'b0 || cmp_done !== 1'b0) begin
                errors++;
                $display("FAIL midcmp_after%0d: got %b expected %b", i, {accel, decel, active, cmp_done, set_speed}, exp_vec());
            end
        end
    endtask

    task automatic test_brake_set();
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'd60);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd60);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 8'd90);
        checks++;
        if (set_speed !== 8'd60 || active !== 1'b0 || {accel, decel, active, cmp_done, set_speed} !== exp_vec()) begin
            errors++;
            $display("FAIL brake_set: got set_speed=%0d active=%b expected set_speed=60 active=0", set_speed, active);
        end
    endtask

    task automatic test_resume();
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'd60);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd60);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 8'd40);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 8'd40);
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd40);
            checks++;
            if ({accel, decel, active, cmp_done, set_speed} !== exp_vec()) begin
                errors++;
                $display("FAIL resume_cycle%0d: got %b expected %b", i, {accel, decel, active, cmp_done, set_speed}, exp_vec());
            end
        end
        checks++;
        if (active !== RES_EN || accel !== RES_EN) begin
            errors++;
            $display("FAIL resume_final: got active=%b accel=%b expected %b %b", active, accel, RES_EN, RES_EN);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] sp;
        sp = 8'd80;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                sp = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 255)) : m_set_speed ^ W'(1 << $urandom_range(0, W - 1));
            end
            tick(($urandom_range(0, 19) != 0), ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0), sp);
            checks++;
            if ({accel, decel, active, cmp_done, set_speed} !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %b expected %b", i, {accel, decel, active, cmp_done, set_speed}, exp_vec());
            end
        end
    endtask

    initial begin
        reset = 1'b1; cruise_on = 1'b0; set = 1'b0; resume = 1'b0; brake = 1'b0; speed = '0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_periodic("accel", 8'h3C, 8'h32, 7, 1'b1, 1'b0);
        test_periodic("decel_msb", 8'h7F, 8'h80, 3, 1'b0, 1'b1);
        test_periodic("equal", 8'd100, 8'd100, 10, 1'b0, 1'b0);
        test_reset_mid_compare();
        test_brake_set();
        test_resume();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
